// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder reused LSB-first across WIDTH clocks.
// Optional subtract mode (i_sub port) is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   b_load_s;
  logic               c_load_s;
  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sum_next_s;
  logic               last_bit_s;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; the caller's carry-in is overridden.
  assign b_load_s = i_sub ? ~i_b : i_b;
  assign c_load_s = i_sub ? 1'b1 : i_c_in;
`else
  assign b_load_s = i_b;
  assign c_load_s = i_c_in;
`endif

  full_adder u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  assign sum_next_s = (sum_sr_q >> 1'b1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit_s = (idx_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath update for IDLE/ADD/DONE sequencing.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_sr_d  = i_a;
          b_sr_d  = b_load_s;
          carry_d = c_load_s;
          idx_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        carry_d  = fa_co;
        sum_sr_d = sum_next_s;
        a_sr_d   = a_sr_q >> 1'b1;
        b_sr_d   = b_sr_q >> 1'b1;
        if (last_bit_s) begin
          sum_d   = sum_next_s;
          cout_d  = fa_co;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_carry = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, random ops vs. an
// arithmetic model, and hand sequences for start-hold, reset abort and spacing.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         i_sub;
`endif
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry;

  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c_in  (i_c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (i_sub),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_carry (o_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Starts one op from a negedge in IDLE, checks timing and the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] exp_sum, input logic exp_carry, input string tag);
    int busy_n;
    int done_n;
    int done_at;
    logic [W-1:0] s_at_done;
    logic         c_at_done;
    i_a = a; i_b = b; i_c_in = cin; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    s_at_done = '0; c_at_done = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (o_busy) busy_n++;
      if (o_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          s_at_done = o_sum;
          c_at_done = o_carry;
        end
      end
    end
    check({tag, " busy_cycles"}, busy_n, W);
    check({tag, " done_count"}, done_n, 1);
    check({tag, " done_at"}, done_at, W + 1);
    check({tag, " sum"}, {24'd0, s_at_done}, {24'd0, exp_sum});
    check({tag, " carry"}, {31'd0, c_at_done}, {31'd0, exp_carry});
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic do_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_carry, input string tag);
    i_sub = 1'b1;
    do_op(a, b, 1'b0, exp_sum, exp_carry, tag);
    i_sub = 1'b0;
  endtask
`endif

  initial begin
    int d1;
    int d2;
    int hold_ok;
    int done_n;
    logic [W-1:0] s1, s2;
    logic         c1, c2;
    logic [W:0]   model;
    logic [W-1:0] ra, rb;
    logic         rc;

    total = 0; bad = 0;
    vecs[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, exp_sum: 8'h7F, exp_carry: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_carry: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_carry: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, exp_sum: 8'h46, exp_carry: 1'b0};
    vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, exp_sum: 8'hFF, exp_carry: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp_sum: 8'h01, exp_carry: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp_sum: 8'h00, exp_carry: 1'b1};
    vecs[7] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp_sum: 8'h00, exp_carry: 1'b0};

    reset_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    i_sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset done", {31'd0, o_done}, 32'd0);
    check("reset sum", {24'd0, o_sum}, 32'd0);
    check("reset carry", {31'd0, o_carry}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle busy", {31'd0, o_busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_carry,
            $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, model[W-1:0], model[W], $sformatf("rnd%0d", i));
    end

    // Start held high, operands changed mid-op: two ops spaced W+2 apart.
    i_a = 8'h12; i_b = 8'h34; i_c_in = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_a = 8'hAA; i_b = 8'h55;
    d1 = -1; d2 = -1; hold_ok = 1; done_n = 0;
    s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int c = 1; c <= 2 * W + 4; c++) begin
      @(negedge clk);
      if (o_done) begin
        done_n++;
        if (d1 < 0) begin d1 = c; s1 = o_sum; c1 = o_carry; end
        else if (d2 < 0) begin d2 = c; s2 = o_sum; c2 = o_carry; end
      end else if (d1 >= 0 && d2 < 0 && o_sum !== 8'h46) begin
        hold_ok = 0;
      end
    end
    i_start = 1'b0;
    check("hold first_done_at", d1, W + 1);
    check("hold second_done_at", d2, 2 * W + 3);
    check("hold done_count", done_n, 2);
    check("hold first_sum", {24'd0, s1}, 32'h46);
    check("hold first_carry", {31'd0, c1}, 32'd0);
    check("hold second_sum", {24'd0, s2}, 32'hFF);
    check("hold second_carry", {31'd0, c2}, 32'd0);
    check("hold sum_between", hold_ok, 1);
    repeat (W + 3) @(negedge clk);

    // Async reset during the 4th ADD cycle aborts with no result.
    do_op(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, "pre_reset");
    i_a = 8'h0F; i_b = 8'h0F; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", {31'd0, o_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", {31'd0, o_busy}, 32'd0);
    check("abort done", {31'd0, o_done}, 32'd0);
    check("abort sum", {24'd0, o_sum}, 32'd0);
    check("abort carry", {31'd0, o_carry}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_n = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (o_done || o_busy) done_n++;
    end
    check("abort no_activity", done_n, 0);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_reset");

`ifdef SERIAL_ADDER_SUB_EN
    do_sub(8'h10, 8'h01, 8'h0F, 1'b1, "sub1");
    do_sub(8'h01, 8'h02, 8'hFF, 1'b0, "sub2");
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      model = {1'b0, ra} + {1'b0, ~rb} + {{W{1'b0}}, 1'b1};
      do_sub(ra, rb, ra - rb, (ra >= rb) ? 1'b1 : 1'b0, $sformatf("rsub%0d", i));
      check($sformatf("rsub%0d model", i), {31'd0, model[W]}, {31'd0, (ra >= rb)});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
